// File: rtl/piso_ctrl_pkg.sv
// Shared definitions for the PISO transmit controller: FSM state encoding
// and a width helper that never returns zero.
package piso_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Bits needed to index n values, never below 1 so degenerate counters stay legal.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register, MSB first with zero fill.
// A load always wins over a shift in the same cycle.
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_in,
    output logic             data_out
);

    logic [WIDTH-1:0] sr_reg;
    logic [WIDTH-1:0] shift_next;

    assign shift_next[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_shift
            assign shift_next[gi] = sr_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_reg <= '0;
        end else if (load) begin
            sr_reg <= data_in;
        end else if (shift_en) begin
            sr_reg <= shift_next;
        end
    end

    assign data_out = sr_reg[WIDTH-1];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Transmit controller: accepts words on valid/ready, sequences the PISO
// register bit by bit with a programmable bit period and inter-word gap.
module piso_tx_ctrl
    import piso_ctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 1,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             pause,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W   = clog2_safe(WIDTH);
    localparam int DIV_W   = clog2_safe(DIV);
    localparam int GAP_CYC = GAP * DIV;
    localparam int GAP_W   = clog2_safe(GAP_CYC + 1);

    localparam logic [BIT_W-1:0] BIT_START = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    state_t           state_reg;
    logic [BIT_W-1:0] bit_cnt_reg;
    logic [DIV_W-1:0] div_cnt_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             ser_valid_reg;
    logic             busy_reg;

    logic accept;
    logic bit_tick;
    logic msb;

    assign in_ready = (state_reg == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    // End of a bit period; pause freezes the divider so no tick is produced.
    assign bit_tick = (state_reg == ST_SHIFT) && !pause && (div_cnt_reg == DIV_LAST);
    // A reset in the final bit discards the word, so no completion is signalled.
    assign done     = bit_tick && (bit_cnt_reg == '0) && !rst;

    piso_shift_reg #(
        .WIDTH (WIDTH)
    ) u_shift_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .shift_en (bit_tick),
        .data_in  (in_data),
        .data_out (msb)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            bit_cnt_reg   <= '0;
            div_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            ser_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg     <= ST_SHIFT;
                        bit_cnt_reg   <= BIT_START;
                        div_cnt_reg   <= '0;
                        ser_valid_reg <= 1'b1;
                        busy_reg      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!pause) begin
                        if (div_cnt_reg == DIV_LAST) begin
                            div_cnt_reg <= '0;
                            if (bit_cnt_reg == '0) begin
                                ser_valid_reg <= 1'b0;
                                if (GAP > 0) begin
                                    state_reg   <= ST_GAP;
                                    gap_cnt_reg <= '0;
                                end else begin
                                    state_reg <= ST_IDLE;
                                    busy_reg  <= 1'b0;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg - BIT_W'(1);
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg + DIV_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    ser_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign ser_valid = ser_valid_reg;
    assign ser_out   = ser_valid_reg && msb;
    assign busy      = busy_reg;

endmodule
